// File: rtl/jtag_pkg.sv
// Shared TAP definitions: controller state encoding and instruction opcodes.
package jtag_pkg;

  typedef enum logic [3:0] {
    TLR, RTI,
    SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR
  } tap_state_e;

  localparam logic [3:0] IDCODE     = 4'h1;
  localparam logic [3:0] USER       = 4'h8;
  localparam logic [3:0] BYPASS     = 4'hF;
  // Fixed pattern loaded at Capture-IR so a host can check scan-chain integrity.
  localparam logic [3:0] IR_CAPTURE = 4'b0101;

endpackage

// File: rtl/jtag_tap_fsm.sv
// IEEE 1149.1 TAP state machine; advances on every rising tck, trst low forces Test-Logic-Reset.
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       tck,
  input  logic       trst,
  input  logic       tms,
  output tap_state_e state
);

  tap_state_e state_q, state_d;

  always_ff @(posedge tck) begin
    if (!trst) state_q <= TLR;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      TLR:    state_d = tms ? TLR    : RTI;
      RTI:    state_d = tms ? SEL_DR : RTI;
      SEL_DR: state_d = tms ? SEL_IR : CAP_DR;
      CAP_DR: state_d = tms ? EX1_DR : SH_DR;
      SH_DR:  state_d = tms ? EX1_DR : SH_DR;
      EX1_DR: state_d = tms ? UPD_DR : PA_DR;
      PA_DR:  state_d = tms ? EX2_DR : PA_DR;
      EX2_DR: state_d = tms ? UPD_DR : SH_DR;
      UPD_DR: state_d = tms ? SEL_DR : RTI;
      SEL_IR: state_d = tms ? TLR    : CAP_IR;
      CAP_IR: state_d = tms ? EX1_IR : SH_IR;
      SH_IR:  state_d = tms ? EX1_IR : SH_IR;
      EX1_IR: state_d = tms ? UPD_IR : PA_IR;
      PA_IR:  state_d = tms ? EX2_IR : PA_IR;
      EX2_IR: state_d = tms ? UPD_IR : SH_IR;
      UPD_IR: state_d = tms ? SEL_DR : RTI;
    endcase
  end

  assign state = state_q;

endmodule

// File: rtl/jtag_tap_ctrl.sv
// TAP controller top: instruction register, IDCODE/USER/BYPASS data registers and registered tdo.
module jtag_tap_ctrl
  import jtag_pkg::*;
#(
  parameter logic [31:0] IDCODE_VAL = 32'h1000_563D,
  parameter int          IR_W       = 4
) (
  input  logic            tck,
  input  logic            trst,
  input  logic            tdi,
  input  logic            tms,
  output logic            tdo,
  output logic            tdo_en,
  output logic [IR_W-1:0] ir_out,
  input  logic [7:0]      status_in,
  output logic [7:0]      ctrl_reg
);

  tap_state_e state;

  jtag_tap_fsm u_fsm (
    .tck   (tck),
    .trst  (trst),
    .tms   (tms),
    .state (state)
  );

  logic [IR_W-1:0] ir_sr_q, ir_sr_d, ir_q, ir_d;
  logic [31:0]     id_sr_q, id_sr_d;
  logic [7:0]      user_sr_q, user_sr_d, ctrl_q, ctrl_d;
  logic            byp_q, byp_d, tdo_q, tdo_d, tdo_en_q, tdo_en_d;
  logic            sel_id, sel_user;

  // Unknown opcodes fall through to BYPASS.
  assign sel_id   = (ir_q == IR_W'(IDCODE));
  assign sel_user = (ir_q == IR_W'(USER));

  always_comb begin
    ir_sr_d   = ir_sr_q;
    ir_d      = ir_q;
    id_sr_d   = id_sr_q;
    user_sr_d = user_sr_q;
    byp_d     = byp_q;
    ctrl_d    = ctrl_q;
    tdo_d     = 1'b0;
    tdo_en_d  = 1'b0;
    unique case (state)
      TLR: begin
        ir_d   = IR_W'(IDCODE);
        ctrl_d = 8'h00;
      end
      CAP_IR: ir_sr_d = IR_W'(IR_CAPTURE);
      SH_IR: begin
        tdo_d    = ir_sr_q[0];
        tdo_en_d = 1'b1;
        ir_sr_d  = {tdi, ir_sr_q[IR_W-1:1]};
      end
      UPD_IR: ir_d = ir_sr_q;
      CAP_DR: begin
        if (sel_id)        id_sr_d   = {IDCODE_VAL[31:1], 1'b1};
        else if (sel_user) user_sr_d = status_in;
        else               byp_d     = 1'b0;
      end
      // tdo takes the bit about to fall off the LSB end, so it appears one tck later.
      SH_DR: begin
        tdo_en_d = 1'b1;
        if (sel_id) begin
          tdo_d   = id_sr_q[0];
          id_sr_d = {tdi, id_sr_q[31:1]};
        end else if (sel_user) begin
          tdo_d     = user_sr_q[0];
          user_sr_d = {tdi, user_sr_q[7:1]};
        end else begin
          tdo_d = byp_q;
          byp_d = tdi;
        end
      end
      UPD_DR: if (sel_user) ctrl_d = user_sr_q;
      default: ;
    endcase
  end

  always_ff @(posedge tck) begin
    if (!trst) begin
      ir_sr_q   <= '0;
      ir_q      <= IR_W'(IDCODE);
      id_sr_q   <= '0;
      user_sr_q <= '0;
      byp_q     <= 1'b0;
      ctrl_q    <= 8'h00;
      tdo_q     <= 1'b0;
      tdo_en_q  <= 1'b0;
    end else begin
      ir_sr_q   <= ir_sr_d;
      ir_q      <= ir_d;
      id_sr_q   <= id_sr_d;
      user_sr_q <= user_sr_d;
      byp_q     <= byp_d;
      ctrl_q    <= ctrl_d;
      tdo_q     <= tdo_d;
      tdo_en_q  <= tdo_en_d;
    end
  end

  assign tdo      = tdo_q;
  assign tdo_en   = tdo_en_q;
  assign ir_out   = ir_q;
  assign ctrl_reg = ctrl_q;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Bench for jtag_tap_ctrl: directed scans plus a randomized run against a string-state reference model.
module tb_jtag_tap_ctrl;
  import jtag_pkg::*;

  logic       tck = 1'b0;
  logic       trst, tdi, tms;
  logic       tdo, tdo_en;
  logic [3:0] ir_out;
  logic [7:0] status_in, ctrl_reg;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 tck = ~tck;

  jtag_tap_ctrl dut (
    .tck       (tck),
    .trst      (trst),
    .tdi       (tdi),
    .tms       (tms),
    .tdo       (tdo),
    .tdo_en    (tdo_en),
    .ir_out    (ir_out),
    .status_in (status_in),
    .ctrl_reg  (ctrl_reg)
  );

  // Reference model: state kept as a name, registers as plain integers.
  string     m_st = "TLR";
  bit [3:0]  m_ir_sr, m_ir = 4'h1;
  bit [31:0] m_id;
  bit [7:0]  m_user, m_ctrl;
  bit        m_byp, m_tdo, m_en;

  function automatic string m_next(string s, bit t);
    case (s)
      "TLR":    return t ? "TLR"    : "RTI";
      "RTI":    return t ? "SEL_DR" : "RTI";
      "SEL_DR": return t ? "SEL_IR" : "CAP_DR";
      "CAP_DR": return t ? "EX1_DR" : "SH_DR";
      "SH_DR":  return t ? "EX1_DR" : "SH_DR";
      "EX1_DR": return t ? "UPD_DR" : "PA_DR";
      "PA_DR":  return t ? "EX2_DR" : "PA_DR";
      "EX2_DR": return t ? "UPD_DR" : "SH_DR";
      "UPD_DR": return t ? "SEL_DR" : "RTI";
      "SEL_IR": return t ? "TLR"    : "CAP_IR";
      "CAP_IR": return t ? "EX1_IR" : "SH_IR";
      "SH_IR":  return t ? "EX1_IR" : "SH_IR";
      "EX1_IR": return t ? "UPD_IR" : "PA_IR";
      "PA_IR":  return t ? "EX2_IR" : "PA_IR";
      "EX2_IR": return t ? "UPD_IR" : "SH_IR";
      "UPD_IR": return t ? "SEL_DR" : "RTI";
      default:  return "TLR";
    endcase
  endfunction

  function automatic tap_state_e to_enum(string s);
    case (s)
      "RTI":    return RTI;
      "SEL_DR": return SEL_DR;
      "CAP_DR": return CAP_DR;
      "SH_DR":  return SH_DR;
      "EX1_DR": return EX1_DR;
      "PA_DR":  return PA_DR;
      "EX2_DR": return EX2_DR;
      "UPD_DR": return UPD_DR;
      "SEL_IR": return SEL_IR;
      "CAP_IR": return CAP_IR;
      "SH_IR":  return SH_IR;
      "EX1_IR": return EX1_IR;
      "PA_IR":  return PA_IR;
      "EX2_IR": return EX2_IR;
      "UPD_IR": return UPD_IR;
      default:  return TLR;
    endcase
  endfunction

  function automatic void model_edge(bit t, bit d, bit rst_n, bit [7:0] st);
    int kind;
    if (!rst_n) begin
      m_st = "TLR"; m_ir_sr = 0; m_ir = 4'h1; m_id = 0; m_user = 0;
      m_byp = 0; m_ctrl = 0; m_tdo = 0; m_en = 0;
      return;
    end
    kind  = (m_ir == 4'h1) ? 0 : (m_ir == 4'h8) ? 1 : 2;
    m_tdo = 0;
    m_en  = 0;
    case (m_st)
      "TLR":    begin m_ir = 4'h1; m_ctrl = 0; end
      "CAP_IR": m_ir_sr = 4'b0101;
      "SH_IR": begin
        m_tdo = m_ir_sr[0]; m_en = 1;
        m_ir_sr = (m_ir_sr >> 1) | (4'(d) << 3);
      end
      "UPD_IR": m_ir = m_ir_sr;
      "CAP_DR": begin
        if (kind == 0)      m_id = 32'h1000_563D;
        else if (kind == 1) m_user = st;
        else                m_byp = 0;
      end
      "SH_DR": begin
        m_en = 1;
        if (kind == 0) begin
          m_tdo = m_id[0]; m_id = (m_id >> 1) | (32'(d) << 31);
        end else if (kind == 1) begin
          m_tdo = m_user[0]; m_user = (m_user >> 1) | (8'(d) << 7);
        end else begin
          m_tdo = m_byp; m_byp = d;
        end
      end
      "UPD_DR": if (kind == 1) m_ctrl = m_user;
      default: ;
    endcase
    m_st = m_next(m_st, t);
  endfunction

  task automatic cyc(input bit t, input bit d);
    tms = t;
    tdi = d;
    @(posedge tck);
    model_edge(t, d, trst, status_in);
    #1;
  endtask

  task automatic do_reset();
    trst = 1'b0;
    cyc(1'b1, 1'b0);
    trst = 1'b1;
  endtask

  task automatic goto_shdr();  // from RTI
    cyc(1, 0); cyc(0, 0); cyc(0, 0);
  endtask

  task automatic goto_shir();  // from RTI
    cyc(1, 0); cyc(1, 0); cyc(0, 0); cyc(0, 0);
  endtask

  task automatic finish_scan();  // from EX1 through Update to RTI
    cyc(1, 0); cyc(0, 0);
  endtask

  // Shift n bits (tms=1 on the last) and collect tdo after each edge.
  task automatic scan(input bit [31:0] din, input int n, output bit [31:0] dout, output bit en_ok);
    dout  = 0;
    en_ok = 1;
    for (int i = 0; i < n; i++) begin
      cyc(i == n - 1, din[i]);
      dout[i] = tdo;
      if (tdo_en !== 1'b1) en_ok = 0;
    end
  endtask

  task automatic test_idcode();
    bit [31:0] o; bit ok;
    do_reset();
    n_tests++;
    if (ir_out !== 4'h1) begin n_fail++; $display("FAIL idcode_ir_after_reset got %h want 1", ir_out); end
    cyc(0, 0);
    goto_shdr();
    scan(32'h0, 32, o, ok);
    n_tests++;
    if (o !== 32'h1000_563D) begin n_fail++; $display("FAIL idcode_value got %h want 1000563d", o); end
    n_tests++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL idcode_tdo_en got %b want 1", ok); end
    finish_scan();
  endtask

  task automatic load_ir(input bit [3:0] v, output bit [3:0] captured);
    bit [31:0] o; bit ok;
    goto_shir();
    scan(32'(v), 4, o, ok);
    captured = o[3:0];
    finish_scan();
  endtask

  task automatic test_ir_scan();
    bit [3:0] c;
    load_ir(4'hF, c);
    n_tests++;
    if (c !== 4'b0101) begin n_fail++; $display("FAIL ir_capture_bits got %b want 0101", c); end
    n_tests++;
    if (ir_out !== 4'hF) begin n_fail++; $display("FAIL ir_out_bypass got %h want f", ir_out); end
  endtask

  task automatic test_bypass();
    bit b0, b1;
    goto_shdr();
    cyc(0, 1); b0 = tdo;
    cyc(1, 1); b1 = tdo;
    n_tests++;
    if ({b1, b0} !== 2'b10) begin n_fail++; $display("FAIL bypass_delay got %b%b want 10", b1, b0); end
    finish_scan();
  endtask

  task automatic test_user();
    bit [31:0] o; bit ok; bit [3:0] c;
    load_ir(4'h8, c);
    n_tests++;
    if (ir_out !== 4'h8) begin n_fail++; $display("FAIL user_ir got %h want 8", ir_out); end
    status_in = 8'h3C;
    goto_shdr();
    scan(32'hA5, 8, o, ok);
    n_tests++;
    if (o[7:0] !== 8'h3C || !ok) begin n_fail++; $display("FAIL user_capture got %h en %b want 3c en 1", o[7:0], ok); end
    finish_scan();
    n_tests++;
    if (ctrl_reg !== 8'hA5) begin n_fail++; $display("FAIL user_update got %h want a5", ctrl_reg); end
  endtask

  task automatic test_reset();
    bit [31:0] o; bit ok;
    goto_shdr();
    cyc(0, 1);
    trst = 1'b0;
    cyc(0, 1);
    trst = 1'b1;
    n_tests++;
    if (dut.state !== TLR || ir_out !== 4'h1 || ctrl_reg !== 8'h00 || tdo !== 1'b0 || tdo_en !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_shift got st=%0d ir=%h ctrl=%h tdo=%b en=%b want st=0 ir=1 ctrl=00 tdo=0 en=0",
               int'(dut.state), ir_out, ctrl_reg, tdo, tdo_en);
    end
    cyc(0, 0);
    n_tests++;
    if (dut.state !== RTI) begin n_fail++; $display("FAIL reset_leave_tlr got %0d want RTI", int'(dut.state)); end
    // Reset arriving while sitting in Update-IR must cancel that update.
    goto_shir();
    scan(32'h8, 4, o, ok);
    cyc(1, 0);
    trst = 1'b0;
    cyc(0, 0);
    trst = 1'b1;
    n_tests++;
    if (ir_out !== 4'h1) begin n_fail++; $display("FAIL reset_suppress_update got %h want 1", ir_out); end
    cyc(0, 0);
  endtask

  task automatic test_tms_reset();
    string names[16] = '{"TLR", "RTI", "SEL_DR", "CAP_DR", "SH_DR", "EX1_DR", "PA_DR", "EX2_DR",
                         "UPD_DR", "SEL_IR", "CAP_IR", "SH_IR", "EX1_IR", "PA_IR", "EX2_IR", "UPD_IR"};
    string paths[16] = '{"", "0", "01", "010", "0100", "0101", "01010", "010101",
                         "01011", "011", "0110", "01100", "01101", "011010", "0110101", "011011"};
    for (int i = 0; i < 16; i++) begin
      do_reset();
      for (int j = 0; j < paths[i].len(); j++) cyc(paths[i].getc(j) == 8'h31, 0);
      n_tests++;
      if (dut.state !== to_enum(names[i])) begin
        n_fail++; $display("FAIL tms_path_%s got %0d", names[i], int'(dut.state));
      end
      for (int k = 0; k < 5; k++) cyc(1, 0);
      n_tests++;
      if (dut.state !== TLR) begin n_fail++; $display("FAIL tms_reset_from_%s got %0d want TLR", names[i], int'(dut.state)); end
    end
    cyc(0, 0);
  endtask

  task automatic test_pause();
    bit [31:0] o1, o2; bit ok1, ok2, b0, b1, en_seen; bit [3:0] c;
    load_ir(4'h1, c);
    goto_shdr();
    scan(32'h0, 10, o1, ok1);
    cyc(0, 0);
    en_seen = 0;
    for (int k = 0; k < 3; k++) begin cyc(0, 1); if (tdo_en !== 1'b0) en_seen = 1; end
    cyc(1, 0);
    cyc(0, 0);
    scan(32'h0, 22, o2, ok2);
    n_tests++;
    if ({o2[21:0], o1[9:0]} !== 32'h1000_563D || !ok1 || !ok2) begin
      n_fail++; $display("FAIL pause_resume got %h want 1000563d", {o2[21:0], o1[9:0]});
    end
    n_tests++;
    if (en_seen) begin n_fail++; $display("FAIL pause_tdo_en got 1 want 0"); end
    finish_scan();
    load_ir(4'h3, c);
    n_tests++;
    if (ir_out !== 4'h3) begin n_fail++; $display("FAIL invalid_ir got %h want 3", ir_out); end
    goto_shdr();
    cyc(0, 1); b0 = tdo;
    cyc(1, 1); b1 = tdo;
    n_tests++;
    if ({b1, b0} !== 2'b10) begin n_fail++; $display("FAIL invalid_ir_bypass got %b%b want 10", b1, b0); end
    finish_scan();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      status_in = 8'($urandom);
      trst      = ($urandom_range(0, 199) != 0);
      cyc($urandom_range(0, 99) < 40, 1'($urandom));
      n_tests++;
      if (dut.state !== to_enum(m_st) || tdo !== m_tdo || tdo_en !== m_en ||
          ir_out !== m_ir || ctrl_reg !== m_ctrl) begin
        n_fail++;
        if (n_fail < 20)
          $display("FAIL random_cycle_%0d got st=%0d tdo=%b en=%b ir=%h ctrl=%h want st=%s tdo=%b en=%b ir=%h ctrl=%h",
                   i, int'(dut.state), tdo, tdo_en, ir_out, ctrl_reg, m_st, m_tdo, m_en, m_ir, m_ctrl);
      end
    end
    trst = 1'b1;
  endtask

  initial begin
    trst = 1'b0; tms = 1'b1; tdi = 1'b0; status_in = 8'h00;
    test_idcode();
    test_ir_scan();
    test_bypass();
    test_user();
    test_reset();
    test_tms_reset();
    test_pause();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
